// File: rtl/hamming_pair_engine_if.sv
// Byte-wide data-memory bus between the pair engine (master) and data memory (slave).
interface hamming_pair_engine_if;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;

   modport master (output mem_addr, output mem_wr_en, output mem_wr_data, input mem_rd_data);
   modport slave  (input mem_addr, input mem_wr_en, input mem_wr_data, output mem_rd_data);
endinterface

// File: rtl/hamming_pair_engine.sv
// Loads NUM_WORDS 16-bit operands from data memory, finds min/max Hamming distance
// over all unordered pairs, writes both back and raises done.
module hamming_pair_engine #(
   parameter int NUM_WORDS   = 32,
   parameter int BASE_ADDR   = 0,
   parameter int RESULT_ADDR = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   hamming_pair_engine_if.master mem,
   output logic                  done,
   output logic [4:0]            min_dist,
   output logic [4:0]            max_dist,
   output logic [4:0]            min_lo,
   output logic [4:0]            min_hi,
   output logic [4:0]            max_lo,
   output logic [4:0]            max_hi
);

   localparam int NBYTES = 2 * NUM_WORDS;
   localparam int CW     = $clog2(NBYTES);
   localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
   localparam logic [4:0]    LAST_J    = 5'(NUM_WORDS - 2);
   localparam logic [4:0]    LAST_K    = 5'(NUM_WORDS - 1);

   typedef enum logic [2:0] {LOAD, COMPARE, WR_MIN, WR_MAX, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [4:0]    j, k;
   logic [15:0]   words [NUM_WORDS];
   logic [7:0]    addr_q, wr_data_q;
   logic          wr_en_q;

   logic [15:0]   diff;
   logic [4:0]    d, min_nx, widx;
   logic          min_upd, max_upd;

   always_comb begin
      diff = words[j] ^ words[k];
      d = '0;
      for (int unsigned b = 0; b < 16; b++) d = d + 5'(diff[b]);
      min_upd = d < min_dist;
      max_upd = d > max_dist;
      min_nx  = min_upd ? d : min_dist;
      widx    = 5'(cnt >> 1);
   end

   assign mem.mem_addr    = addr_q;
   assign mem.mem_wr_data = wr_data_q;
   // Reset kills the strobe in the same cycle so an abort never lands a write.
   assign mem.mem_wr_en   = wr_en_q & ~reset;

   always_ff @(posedge clk) begin
      if (!reset && state == LOAD) begin
         if (cnt[0]) words[widx][7:0]  <= mem.mem_rd_data;
         else        words[widx][15:8] <= mem.mem_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOAD;
         cnt       <= '0;
         addr_q    <= 8'(BASE_ADDR);
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         done      <= 1'b0;
         min_dist  <= 5'd16;
         max_dist  <= '0;
         min_lo    <= '0;
         min_hi    <= '0;
         max_lo    <= '0;
         max_hi    <= '0;
         j         <= '0;
         k         <= 5'd1;
      end else begin
         case (state)
            LOAD: begin
               addr_q <= 8'(BASE_ADDR + int'(cnt) + 1);
               if (cnt == LAST_BYTE) begin
                  state <= COMPARE;
                  j     <= '0;
                  k     <= 5'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            COMPARE: begin
               if (min_upd) begin
                  min_dist <= d;
                  min_lo   <= j;
                  min_hi   <= k;
               end
               if (max_upd) begin
                  max_dist <= d;
                  max_lo   <= j;
                  max_hi   <= k;
               end
               if (k == LAST_K) begin
                  if (j == LAST_J) begin
                     // Last pair's update is folded into the first write's data.
                     state     <= WR_MIN;
                     addr_q    <= 8'(RESULT_ADDR);
                     wr_data_q <= {3'b000, min_nx};
                     wr_en_q   <= 1'b1;
                  end else begin
                     j <= j + 5'd1;
                     k <= j + 5'd2;
                  end
               end else begin
                  k <= k + 5'd1;
               end
            end
            WR_MIN: begin
               state     <= WR_MAX;
               addr_q    <= 8'(RESULT_ADDR + 1);
               wr_data_q <= {3'b000, max_dist};
            end
            WR_MAX: begin
               state   <= DONE;
               wr_en_q <= 1'b0;
               done    <= 1'b1;
            end
            DONE: ;
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_pair_engine.sv
// Self-checking bench for hamming_pair_engine: directed pattern table, random
// operand sets against a pairwise software model, abort and preload sequences.
module tb_hamming_pair_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       done;
   logic [4:0] min_dist, max_dist, min_lo, min_hi, max_lo, max_hi;
   logic [7:0] mem [256];
   logic [7:0] snap [256];
   int         vectors = 0;
   int         miscompares = 0;
   int         bad_writes = 0;
   int         abort_writes = 0;

   hamming_pair_engine_if bus ();

   hamming_pair_engine #(.NUM_WORDS(32), .BASE_ADDR(0), .RESULT_ADDR(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .mem      (bus.master),
      .done     (done),
      .min_dist (min_dist),
      .max_dist (max_dist),
      .min_lo   (min_lo),
      .min_hi   (min_hi),
      .max_lo   (max_lo),
      .max_hi   (max_hi)
   );

   always #5 clk = ~clk;

   assign bus.mem_rd_data = mem[bus.mem_addr];

   always @(posedge clk) begin
      if (bus.mem_wr_en) begin
         if (bus.mem_addr != 8'd64 && bus.mem_addr != 8'd65) bad_writes++;
         if (reset) abort_writes++;
         mem[bus.mem_addr] = bus.mem_wr_data;
      end
   end

   typedef struct {
      int pattern;
      int mn, mx, mnl, mnh, mxl, mxh;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_pattern(input int p);
      logic [15:0] w;
      for (int i = 0; i < 32; i++) begin
         case (p)
            0:       w = 16'h0000;
            1:       w = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
            2:       w = 16'(1 << (i % 16));
            default: w = 16'($urandom);
         endcase
         mem[2*i]   = w[15:8];
         mem[2*i+1] = w[7:0];
      end
   endtask

   // Brute-force over every unordered pair; strict compares keep the first pair.
   task automatic model(output int mn, output int mx, output int mnl, output int mnh,
                        output int mxl, output int mxh);
      int w [32];
      int dd;
      for (int i = 0; i < 32; i++) w[i] = {mem[2*i], mem[2*i+1]};
      mn = 16; mx = 0; mnl = 0; mnh = 0; mxl = 0; mxh = 0;
      for (int a = 0; a < 32; a++)
         for (int b = a + 1; b < 32; b++) begin
            dd = $countones(16'(w[a] ^ w[b]));
            if (dd < mn) begin mn = dd; mnl = a; mnh = b; end
            if (dd > mx) begin mx = dd; mxl = a; mxh = b; end
         end
   endtask

   task automatic hold_reset();
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
   endtask

   // Release reset and count edges until done rises, bounded.
   task automatic run(output int lat);
      lat = 0;
      @(negedge clk) reset = 1'b0;
      while (lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (done) break;
      end
   endtask

   task automatic check_results(input string tag, input int mn, input int mx, input int mnl,
                                input int mnh, input int mxl, input int mxh);
      check({tag, " mem64"}, mem[64], mn);
      check({tag, " mem65"}, mem[65], mx);
      check({tag, " min_dist"}, min_dist, mn);
      check({tag, " max_dist"}, max_dist, mx);
      check({tag, " min_lo"}, min_lo, mnl);
      check({tag, " min_hi"}, min_hi, mnh);
      check({tag, " max_lo"}, max_lo, mxl);
      check({tag, " max_hi"}, max_hi, mxh);
   endtask

   initial begin
      vec_t tbl [3];
      int lat, mn, mx, mnl, mnh, mxl, mxh, changed, held;

      tbl[0] = '{pattern: 0, mn: 0, mx: 0,  mnl: 0, mnh: 1,  mxl: 0, mxh: 0};
      tbl[1] = '{pattern: 1, mn: 0, mx: 16, mnl: 0, mnh: 2,  mxl: 0, mxh: 1};
      tbl[2] = '{pattern: 2, mn: 0, mx: 2,  mnl: 0, mnh: 16, mxl: 0, mxh: 1};

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset addr", bus.mem_addr, 0);
      check("reset wr_en", bus.mem_wr_en, 0);
      check("reset wr_data", bus.mem_wr_data, 0);
      check("reset done", done, 0);
      check("reset min_dist", min_dist, 16);
      check("reset max_dist", max_dist, 0);
      check("reset indices", {min_lo, min_hi, max_lo, max_hi}, 0);

      for (int t = 0; t < 3; t++) begin
         hold_reset();
         fill_pattern(tbl[t].pattern);
         mem[64] = 8'hAA; mem[65] = 8'hAA;
         run(lat);
         check($sformatf("pat%0d latency", t), lat, 562);
         check_results($sformatf("pat%0d", t), tbl[t].mn, tbl[t].mx, tbl[t].mnl,
                       tbl[t].mnh, tbl[t].mxl, tbl[t].mxh);
      end

      // Exactly one edge short of completion, done must still be low.
      hold_reset();
      fill_pattern(0);
      @(negedge clk) reset = 1'b0;
      repeat (561) @(posedge clk);
      #1;
      check("done before E562", done, 0);
      @(posedge clk); #1;
      check("done at E562", done, 1);

      for (int r = 0; r < 4; r++) begin
         hold_reset();
         fill_pattern(3);
         mem[64] = 8'hAA; mem[65] = 8'hAA;
         model(mn, mx, mnl, mnh, mxl, mxh);
         run(lat);
         check($sformatf("rand%0d latency", r), lat, 562);
         check_results($sformatf("rand%0d", r), mn, mx, mnl, mnh, mxl, mxh);
      end

      // Abort at E300, release 5 cycles later, then a clean rerun.
      hold_reset();
      fill_pattern(3);
      mem[64] = 8'hAA; mem[65] = 8'hAA;
      model(mn, mx, mnl, mnh, mxl, mxh);
      @(negedge clk) reset = 1'b0;
      repeat (299) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("abort done", done, 0);
      check("abort min_dist", min_dist, 16);
      check("abort max_dist", max_dist, 0);
      check("abort mem64", mem[64], 8'hAA);
      check("abort mem65", mem[65], 8'hAA);
      run(lat);
      check("rerun latency", lat, 562);
      check_results("rerun", mn, mx, mnl, mnh, mxl, mxh);

      // Preloaded result area: only the two result bytes may change.
      hold_reset();
      fill_pattern(3);
      mem[64] = 8'd16;
      for (int i = 65; i < 256; i++) mem[i] = 8'h00;
      if (mem[66] == 8'h00) mem[66] = 8'h00;
      for (int i = 0; i < 256; i++) snap[i] = mem[i];
      model(mn, mx, mnl, mnh, mxl, mxh);
      run(lat);
      check("preload latency", lat, 562);
      check_results("preload", mn, mx, mnl, mnh, mxl, mxh);
      changed = 0;
      for (int i = 0; i < 256; i++)
         if (i != 64 && i != 65 && mem[i] !== snap[i]) changed++;
      check("preload untouched bytes", changed, 0);
      held = 1;
      repeat (100) begin
         @(posedge clk); #1;
         if (done !== 1'b1) held = 0;
         if (bus.mem_wr_en !== 1'b0) held = 0;
      end
      check("done held", held, 1);
      hold_reset();
      check("done falls on reset", done, 0);

      check("stray writes", bad_writes, 0);
      check("writes under reset", abort_writes, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
